// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 pipelined slave driving a 16-bit asynchronous SRAM.
// Registered strobes, programmable wait states, stall held until accept.
//
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  wb_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//  wb_adr_i/dat_i/sel_i       word address, write data, byte selects
//  wb_dat_o/ack_o/stall_o     read data, acknowledge, stall
//  sram_addr, sram_dq_i/o     SRAM address and data pads
//  sram_dq_oe                 data pad output enable
//  sram_ce_n/oe_n/we_n        chip, output and write enables
//  sram_ub_n/lb_n             upper/lower byte enables
module wb_sram_ctrl #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [1:0]            wb_sel_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dq_i,
  output logic [DATA_WIDTH-1:0] sram_dq_o,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nx;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nx;
  logic                  r_we;
  logic                  w_we_nx;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_dq_o;
  logic [DATA_WIDTH-1:0] w_dat;
  logic                  w_ack;
  logic                  w_stall;
  logic                  w_ce_n;
  logic                  w_oe_n;
  logic                  w_we_n;
  logic                  w_ub_n;
  logic                  w_lb_n;
  logic                  w_dq_oe;

  // Every output is computed one cycle ahead and registered,
  // so the values below are what the pins show next cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_we_nx    = r_we;
    w_addr     = sram_addr;
    w_dq_o     = sram_dq_o;
    w_dat      = wb_dat_o;
    w_ack      = 1'b0;
    w_stall    = 1'b1;
    w_ce_n     = 1'b1;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_ub_n     = 1'b1;
    w_lb_n     = 1'b1;
    w_dq_oe    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_state_nx = S_ACCESS;
          w_cnt_nx   = CNT_INIT;
          w_we_nx    = wb_we_i;
          w_addr     = wb_adr_i;
          w_dq_o     = wb_dat_i;
          w_ce_n     = 1'b0;
          w_oe_n     = wb_we_i;
          w_we_n     = ~wb_we_i;
          w_ub_n     = ~wb_sel_i[1];
          w_lb_n     = ~wb_sel_i[0];
          w_dq_oe    = wb_we_i;
          // single wait state: first access cycle is the accept cycle
          w_stall    = (CNT_INIT != 4'd0);
        end
      end
      S_ACCESS: begin
        if (!wb_cyc_i) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nx = S_ACK;
          w_ack      = 1'b1;
          // keep driving write data one extra cycle for hold time
          w_dq_oe    = r_we;
          if (!r_we) begin
            w_dat = sram_dq_i;
          end
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
          w_ce_n   = sram_ce_n;
          w_oe_n   = sram_oe_n;
          w_we_n   = sram_we_n;
          w_ub_n   = sram_ub_n;
          w_lb_n   = sram_lb_n;
          w_dq_oe  = sram_dq_oe;
          w_stall  = (r_cnt != 4'd1);
        end
      end
      S_ACK: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      wb_stall_o <= 1'b1;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_we       <= w_we_nx;
      sram_addr  <= w_addr;
      sram_dq_o  <= w_dq_o;
      wb_dat_o   <= w_dat;
      wb_ack_o   <= w_ack;
      wb_stall_o <= w_stall;
      sram_ce_n  <= w_ce_n;
      sram_oe_n  <= w_oe_n;
      sram_we_n  <= w_we_n;
      sram_ub_n  <= w_ub_n;
      sram_lb_n  <= w_lb_n;
      sram_dq_oe <= w_dq_oe;
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Testbench for wb_sram_ctrl: two instances (2 and 1 wait states),
// behavioural SRAM device, per-cycle timing model and literal checks.
module tb_wb_sram_ctrl;

  localparam int AW = 18;
  localparam int DW = 16;

  typedef struct {
    bit            v;
    int            t0;
    bit            we;
    logic [1:0]    sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    int            ab;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cnt;
  int n_chk;
  int n_fail;

  logic          rst_n [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [AW-1:0] adr   [2];
  logic [DW-1:0] dat   [2];
  logic [1:0]    sel   [2];
  logic [DW-1:0] dat_o [2];
  logic          ack   [2];
  logic          stall [2];
  logic [AW-1:0] sa    [2];
  logic [DW-1:0] dq_i  [2];
  logic [DW-1:0] dq_o  [2];
  logic          dq_oe [2];
  logic          ce_n  [2];
  logic          oe_n  [2];
  logic          we_n  [2];
  logic          ub_n  [2];
  logic          lb_n  [2];

  logic [DW-1:0] sram [2][1024];
  logic [DW-1:0] refm [2][1024];
  txn_t          txn  [2];
  logic [AW-1:0] exp_addr [2];
  logic [DW-1:0] exp_dqo  [2];
  logic [DW-1:0] exp_dat  [2];

  task automatic chk(input int g, input string nm,
                     input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc %0d: got %h expected %h",
               nm, g, cnt, a, e);
    end
  endtask

  task automatic tmo(input int g, input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s[%0d] cyc %0d: timeout", nm, g, cnt);
  endtask

  initial begin
    cnt = 0;
    forever begin
      @(posedge clk);
      cnt++;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : 1;

    wb_sram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .wb_cyc_i  (cyc[g]),
      .wb_stb_i  (stb[g]),
      .wb_we_i   (we[g]),
      .wb_adr_i  (adr[g]),
      .wb_dat_i  (dat[g]),
      .wb_sel_i  (sel[g]),
      .wb_dat_o  (dat_o[g]),
      .wb_ack_o  (ack[g]),
      .wb_stall_o(stall[g]),
      .sram_addr (sa[g]),
      .sram_dq_i (dq_i[g]),
      .sram_dq_o (dq_o[g]),
      .sram_dq_oe(dq_oe[g]),
      .sram_ce_n (ce_n[g]),
      .sram_oe_n (oe_n[g]),
      .sram_we_n (we_n[g]),
      .sram_ub_n (ub_n[g]),
      .sram_lb_n (lb_n[g])
    );

    // asynchronous SRAM: reads flow through while selected,
    // 16'hDEAD otherwise so a mistimed capture is visible
    assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ?
                     sram[g][sa[g][9:0]] : 16'hDEAD;

    initial begin : dev_wr
      forever begin
        @(posedge clk);
        if (!ce_n[g] && !we_n[g] && dq_oe[g]) begin
          if (!ub_n[g]) sram[g][sa[g][9:0]][15:8] = dq_o[g][15:8];
          if (!lb_n[g]) sram[g][sa[g][9:0]][7:0]  = dq_o[g][7:0];
        end
      end
    end

    // timing model: outputs as a function of cycles since request
    initial begin : cmp
      int         k;
      bit         act;
      logic [7:0] ectl;
      logic [9:0] ix;
      forever begin
        @(negedge clk);
        if (!rst_n[g]) begin
          exp_addr[g] = '0;
          exp_dqo[g]  = '0;
          exp_dat[g]  = '0;
          ectl = 8'b0111_1110;
        end else begin
          k   = cnt - txn[g].t0;
          act = txn[g].v && (k >= 1) &&
                !(txn[g].ab != 0 && k > txn[g].ab);
          ix  = txn[g].adr[9:0];
          if (act && k == 1) begin
            exp_addr[g] = txn[g].adr;
            exp_dqo[g]  = txn[g].dat;
          end
          if (act && k <= W) begin
            ectl = {1'b0, (k == W) ? 1'b0 : 1'b1, 1'b0,
                    txn[g].we, ~txn[g].we,
                    ~txn[g].sel[1], ~txn[g].sel[0], txn[g].we};
          end else if (act && k == W + 1) begin
            ectl = {7'b1111111, txn[g].we};
            if (txn[g].we) begin
              if (txn[g].sel[1]) refm[g][ix][15:8] = txn[g].dat[15:8];
              if (txn[g].sel[0]) refm[g][ix][7:0]  = txn[g].dat[7:0];
            end else begin
              exp_dat[g] = refm[g][ix];
            end
          end else begin
            ectl = 8'b0111_1110;
          end
        end
        chk(g, "ctl", {ack[g], stall[g], ce_n[g], oe_n[g], we_n[g],
                       ub_n[g], lb_n[g], dq_oe[g]}, ectl);
        chk(g, "addr", sa[g], exp_addr[g]);
        chk(g, "dq_o", dq_o[g], exp_dqo[g]);
        chk(g, "dat_o", dat_o[g], exp_dat[g]);
      end
    end
  end

  task automatic xfer(input int g, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] s,
                      input int ab, output logic [DW-1:0] rd);
    bit seen;
    rd = '0;
    @(posedge clk);
    #1;
    cyc[g] = 1'b1;
    stb[g] = 1'b1;
    we[g]  = w;
    adr[g] = a;
    dat[g] = d;
    sel[g] = s;
    txn[g].t0  = cnt;
    txn[g].we  = w;
    txn[g].sel = s;
    txn[g].adr = a;
    txn[g].dat = d;
    txn[g].ab  = ab;
    txn[g].v   = 1'b1;
    if (ab != 0) begin
      repeat (ab) @(posedge clk);
      #1;
      cyc[g] = 1'b0;
      stb[g] = 1'b0;
      repeat (3) @(posedge clk);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!stall[g]) seen = 1'b1;
    end
    if (!seen) tmo(g, "accept");
    @(posedge clk);
    #1;
    stb[g] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack[g]) seen = 1'b1;
    end
    if (!seen) tmo(g, "ack");
    rd = dat_o[g];
    @(posedge clk);
    #1;
    cyc[g] = 1'b0;
    we[g]  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    n_chk  = 0;
    n_fail = 0;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      cyc[g] = 1'b0;
      stb[g] = 1'b0;
      we[g]  = 1'b0;
      adr[g] = '0;
      dat[g] = '0;
      sel[g] = 2'b00;
      for (int i = 0; i < 1024; i++) begin
        sram[g][i] = '0;
        refm[g][i] = '0;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_lit", {stall[g], ce_n[g], oe_n[g], we_n[g],
                         ub_n[g], lb_n[g], dq_oe[g], ack[g]}, 8'hFC);
      chk(g, "rst_dat", dat_o[g], 16'h0000);
    end

    xfer(0, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 0, rd);
    xfer(0, 1'b0, 18'h00123, 16'h0000, 2'b11, 0, rd);
    chk(0, "rd_beef", rd, 16'hBEEF);
    xfer(0, 1'b1, 18'h00123, 16'h1234, 2'b01, 0, rd);
    xfer(0, 1'b0, 18'h00123, 16'h0000, 2'b11, 0, rd);
    chk(0, "rd_be34", rd, 16'hBE34);
    xfer(0, 1'b1, 18'h00123, 16'hFFFF, 2'b00, 0, rd);
    xfer(0, 1'b0, 18'h00123, 16'h0000, 2'b10, 0, rd);
    chk(0, "rd_sel00", rd, 16'hBE34);

    @(posedge clk);
    #1;
    stb[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stb[0] = 1'b0;

    xfer(0, 1'b1, 18'h00200, 16'h5A5A, 2'b11, 1, rd);
    xfer(0, 1'b0, 18'h00123, 16'h0000, 2'b11, 0, rd);
    chk(0, "rd_abort", rd, 16'hBE34);

    xfer(1, 1'b1, 18'h00055, 16'hA5C3, 2'b11, 0, rd);
    xfer(1, 1'b0, 18'h00055, 16'h0000, 2'b11, 0, rd);
    chk(1, "rd_a5c3", rd, 16'hA5C3);

    @(posedge clk);
    #1;
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    we[1]  = 1'b1;
    adr[1] = 18'h00077;
    dat[1] = 16'h7777;
    sel[1] = 2'b11;
    txn[1].t0  = cnt;
    txn[1].we  = 1'b1;
    txn[1].sel = 2'b11;
    txn[1].adr = 18'h00077;
    txn[1].dat = 16'h7777;
    txn[1].ab  = 0;
    txn[1].v   = 1'b1;
    @(posedge clk);
    #2;
    chk(1, "pre_rst", {ce_n[1], we_n[1], dq_oe[1]}, 3'b001);
    rst_n[1]  = 1'b0;
    txn[1].v  = 1'b0;
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    we[1]  = 1'b0;
    #1;
    chk(1, "async_rst", {ack[1], ce_n[1], oe_n[1], we_n[1],
                         ub_n[1], lb_n[1], dq_oe[1]}, 7'b0111110);
    repeat (2) @(posedge clk);
    #2;
    rst_n[1] = 1'b1;

    xfer(1, 1'b1, 18'h00055, 16'h0F0F, 2'b11, 0, rd);
    xfer(1, 1'b0, 18'h00055, 16'h0000, 2'b11, 0, rd);
    chk(1, "rd_0f0f", rd, 16'h0F0F);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
